// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan path.
//   - scan_state_e : scan FSM encoding (OFF / BLANK / SHOW)
//   - SEG_0..SEG_F : segment glyphs, bit 6..0 = g..a, active-high
//   - SEG_BLANK    : all segments off
//   - SEG_DP_BIT   : position of the decimal point in the 8-bit seg_data bus
//   - seg_pack()   : builds {dp,g,f,e,d,c,b,a} from a dp bit and a glyph
package seg_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // seg_data bus order is {dp,g,f,e,d,c,b,a}
    localparam int SEG_DP_BIT = 7;

    function automatic logic [7:0] seg_pack(input logic dp, input logic [6:0] seg);
        logic [7:0] r;
        r             = {1'b0, seg};
        r[SEG_DP_BIT] = dp;
        return r;
    endfunction

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational nibble-to-glyph decoder for 7-segment displays.
//   bcd : 4-bit digit value (0-9, A-F shown as hex glyphs)
//   seg : segments {g,f,e,d,c,b,a}, active-high
module seg_bcd_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-cathode 7-segment display.
// Each rising edge of div_clk advances to the next digit; every digit change
// is preceded by BLANK_CYCLES clocks with all digits off to avoid ghosting.
// The displayed value is snapshotted once per frame (when the scan wraps to
// digit 0), so a frame never mixes old and new digits.
//   clk        : system clock
//   rst        : asynchronous reset, active-low
//   div_clk    : scan clock level, synchronous to clk
//   digits_bcd : digit i at [4i+3:4i], digit 0 rightmost
//   dp_in      : decimal point per digit, active-high
//   blank_mask : 1 = digit suppressed
//   seg_com    : digit enables, active-low, at most one bit low
//   seg_data   : {dp,g,f,e,d,c,b,a}, active-high
//   frame_done : one-clk pulse after a new frame snapshot is taken
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    div_clk,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   seg_com,
    output logic [7:0]              seg_data,
    output logic                    frame_done
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [7:0]       CNT_LAST = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);
    localparam bit               NO_BLANK = (BLANK_CYCLES == 0);

    logic                             div_d1_q,      div_d1_d;
    scan_state_e                      state_q,       state_d;
    logic [IDX_W-1:0]                 idx_q,         idx_d;
    logic [7:0]                       cnt_q,         cnt_d;
    logic [NUM_DIGITS-1:0][3:0]       shadow_bcd_q,  shadow_bcd_d;
    logic [NUM_DIGITS-1:0]            shadow_dp_q,   shadow_dp_d;
    logic [NUM_DIGITS-1:0]            shadow_mask_q, shadow_mask_d;
    logic                             frame_done_q,  frame_done_d;
    logic [NUM_DIGITS-1:0]            seg_com_q,     seg_com_d;
    logic [7:0]                       seg_data_q,    seg_data_d;

    logic       tick;
    logic       wrap;
    logic [3:0] cur_bcd;
    logic [6:0] cur_seg;

    assign tick = div_clk & ~div_d1_q;
    assign wrap = (idx_q == IDX_LAST);

    // Next-state: digit sequencing, blanking counter and frame snapshot.
    always_comb begin
        div_d1_d      = div_clk;
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        shadow_bcd_d  = shadow_bcd_q;
        shadow_dp_d   = shadow_dp_q;
        shadow_mask_d = shadow_mask_q;
        frame_done_d  = 1'b0;

        if (tick) begin
            // A tick wins in every state; in BLANK it restarts blanking for
            // the new digit so the skipped digit never shows.
            idx_d   = wrap ? '0 : idx_q + IDX_ONE;
            cnt_d   = 8'd0;
            state_d = NO_BLANK ? ST_SHOW : ST_BLANK;
            if (wrap) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    shadow_bcd_d[i] = digits_bcd[4*i +: 4];
                end
                shadow_dp_d   = dp_in;
                shadow_mask_d = blank_mask;
                frame_done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                ST_BLANK: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cur_bcd = shadow_bcd_d[idx_d];

    seg_bcd_decode u_decode (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    // Outputs are computed from next-state values so the pins are plain
    // registers and change exactly one clock after the state decision.
    always_comb begin
        seg_com_d  = '1;
        seg_data_d = 8'h00;
        if (state_d == ST_SHOW && !shadow_mask_d[idx_d]) begin
            seg_com_d[idx_d] = 1'b0;
            seg_data_d       = seg_pack(shadow_dp_d[idx_d], cur_seg);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_d1_q      <= 1'b0;
            state_q       <= ST_OFF;
            idx_q         <= IDX_LAST;
            cnt_q         <= 8'd0;
            shadow_bcd_q  <= '0;
            shadow_dp_q   <= '0;
            shadow_mask_q <= '0;
            frame_done_q  <= 1'b0;
            seg_com_q     <= '1;
            seg_data_q    <= 8'h00;
        end else begin
            div_d1_q      <= div_d1_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            shadow_bcd_q  <= shadow_bcd_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_mask_q <= shadow_mask_d;
            frame_done_q  <= frame_done_d;
            seg_com_q     <= seg_com_d;
            seg_data_q    <= seg_data_d;
        end
    end

    assign seg_com    = seg_com_q;
    assign seg_data   = seg_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver. The reference model tracks only "which digit is
// current", "clocks elapsed since the last tick" and the per-frame snapshot;
// expected pins follow from those with plain arithmetic.
module tb_seg_scan_driver;

    localparam int ND = 8;
    localparam int BC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            div_clk = 1'b0;
    logic [4*ND-1:0] digits_bcd = '0;
    logic [ND-1:0]   dp_in = '0;
    logic [ND-1:0]   blank_mask = '0;
    logic [ND-1:0]   seg_com;
    logic [7:0]      seg_data;
    logic            frame_done;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(ND), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_clk    (div_clk),
        .digits_bcd (digits_bcd),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .seg_com    (seg_com),
        .seg_data   (seg_data),
        .frame_done (frame_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int            m_idx;
    int            m_since;   // clocks since last tick; 0 = no tick since reset
    logic          m_prev;
    logic          m_fd;
    logic [3:0]    m_bcd [ND];
    logic [ND-1:0] m_dp;
    logic [ND-1:0] m_mask;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic m_reset();
        m_idx   = ND - 1;
        m_since = 0;
        m_prev  = 1'b0;
        m_fd    = 1'b0;
        for (int i = 0; i < ND; i++) m_bcd[i] = 4'h0;
        m_dp    = '0;
        m_mask  = '0;
    endtask

    task automatic check_outputs();
        logic [ND-1:0] e_com;
        logic [7:0]    e_data;
        e_com  = '1;
        e_data = 8'h00;
        if (m_since > BC && !m_mask[m_idx]) begin
            e_com[m_idx] = 1'b0;
            e_data       = {m_dp[m_idx], glyph[m_bcd[m_idx]]};
        end
        chk("seg_com", 32'(seg_com), 32'(e_com));
        chk("seg_data", 32'(seg_data), 32'(e_data));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    // One clock: called just after a rising edge, returns just after the next.
    task automatic cycle(input logic dv);
        logic tk;
        div_clk = dv;
        tk      = dv & ~m_prev;
        @(posedge clk);
        if (rst) begin
            m_prev = dv;
            m_fd   = 1'b0;
            if (tk) begin
                m_idx   = (m_idx + 1) % ND;
                m_since = 1;
                if (m_idx == 0) begin
                    for (int i = 0; i < ND; i++) m_bcd[i] = digits_bcd[4*i +: 4];
                    m_dp   = dp_in;
                    m_mask = blank_mask;
                    m_fd   = 1'b1;
                end
            end else if (m_since > 0) begin
                m_since++;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int  fd_cnt;
        int  lvl;
        int  runlen;
        bit  found;

        m_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;

        // idle: no div_clk edges, inputs wiggle but must not be captured
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) digits_bcd = $urandom;
            cycle(1'b0);
        end

        // standard scan, value changed while digit 3 is showing
        digits_bcd = 32'h0000_0021;
        dp_in      = '0;
        blank_mask = '0;
        for (int k = 0; k < 17000; k++) begin
            if (k == 7000) digits_bcd = 32'h0000_0009;
            cycle((k % 2000) < 1000);
            if (k == 0)     chk("first_fd", 32'(frame_done), 32'd1);
            if (k == 3)     chk("blank_end_com", 32'(seg_com), 32'hFF);
            if (k == 4)     chk("d0_com", 32'(seg_com), 32'hFE);
            if (k == 4)     chk("d0_data", 32'(seg_data), 32'h06);
            if (k == 2004)  chk("d1_com", 32'(seg_com), 32'hFD);
            if (k == 2004)  chk("d1_data", 32'(seg_data), 32'h5B);
            if (k == 14004) chk("old_d7_data", 32'(seg_data), 32'h3F);
            if (k == 16004) chk("new_d0_com", 32'(seg_com), 32'hFE);
            if (k == 16004) chk("new_d0_data", 32'(seg_data), 32'h6F);
        end

        // masked digit and decimal point
        do_reset();
        blank_mask = 8'h02;
        dp_in      = 8'h01;
        digits_bcd = 32'h0000_0015;
        for (int k = 0; k < 6000; k++) begin
            cycle((k % 2000) < 1000);
            if (k == 4)    chk("dp_data", 32'(seg_data), 32'hED);
            if (k == 2004) chk("mask_com", 32'(seg_com), 32'hFF);
            if (k == 2004) chk("mask_data", 32'(seg_data), 32'h00);
        end

        // fast div_clk: ticks every 3 clocks, blanking never completes
        do_reset();
        fd_cnt = 0;
        for (int k = 0; k < 240; k++) begin
            cycle(k % 3 == 0);
            if (frame_done) fd_cnt++;
        end
        chk("fast_fd_count", 32'(fd_cnt), 32'd10);

        // randomized scan with random run lengths and input changes
        do_reset();
        lvl    = 0;
        runlen = 0;
        for (int k = 0; k < 20000; k++) begin
            if (runlen == 0) begin
                lvl    = 1 - lvl;
                runlen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 60);
            end
            if ($urandom_range(0, 199) == 0) begin
                digits_bcd = $urandom;
                dp_in      = 8'($urandom);
                blank_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            end
            cycle(lvl[0]);
            runlen--;
        end

        // asynchronous reset while digit 5 is showing
        do_reset();
        blank_mask = '0;
        found      = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            cycle((k % 40) < 20);
            if (m_idx == 5 && m_since > BC + 2) found = 1'b1;
        end
        chk("reach_digit5", 32'(found), 32'd1);
        chk("d5_showing", 32'(seg_com), 32'hDF);
        #3;
        rst = 1'b0;
        m_reset();
        #1;
        chk("rst_com", 32'(seg_com), 32'hFF);
        chk("rst_data", 32'(seg_data), 32'h00);
        check_outputs();
        @(posedge clk);
        #1;
        div_clk = 1'b1;
        rst     = 1'b1;
        for (int i = 0; i < BC + 1; i++) cycle(1'b1);
        chk("post_rst_d0", 32'(seg_com), 32'hFE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
